ilog2_pipe: RTL and testbench

Parametrised, pipelined floor-log2 unit: computes the bit position of the most-significant set bit of a WIDTH-bit unsigned operand. It is the streaming successor of the 32-bit combinational log2 encoder, used by the chaining-score datapath for gap-cost lookups. It carries a sideband tag, flags zero operands, and applies valid/ready backpressure. An optional fractional output gives an approximate log2 for finer gap-cost resolution.

---
 rtl/ilog2_pipe_if.sv | 38 +++
 rtl/ilog2_pipe.sv | 131 +++++++++++++
 tb/tb_ilog2_pipe.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ilog2_pipe_if.sv
// Streaming handshake bundle for ilog2_pipe: operand/tag in, log2 result out.
// out_frac exists only when ILOG2_FRAC_EN is defined.
interface ilog2_pipe_if #(
   parameter int WIDTH     = 32,
   parameter int TAG_W     = 8,
   parameter int FRAC_BITS = 4
);
   localparam int LW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [LW-1:0]    out_pos;
   logic             out_zero;
`ifdef ILOG2_FRAC_EN
   logic [FRAC_BITS-1:0] out_frac;
`endif
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_data, in_tag, out_ready,
`ifdef ILOG2_FRAC_EN
      input  out_frac,
`endif
      input  in_ready, out_valid, out_pos, out_zero, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
`ifdef ILOG2_FRAC_EN
      output out_frac,
`endif
      output in_ready, out_valid, out_pos, out_zero, out_tag
   );
endinterface

// File: rtl/ilog2_pipe.sv
// Pipelined floor-log2: LW-stage leading-zero normalise chain with global stall.
// Define ILOG2_FRAC_EN to carry the full word and expose out_frac.
module ilog2_pipe #(
   parameter int WIDTH     = 32,
   parameter int TAG_W     = 8,
   parameter int FRAC_BITS = 4
) (
   input  logic          clk,
   input  logic          rst,
   ilog2_pipe_if.slave   io
);
   localparam int LW = $clog2(WIDTH);
   localparam int L  = LW - 1;

   logic             adv;
   logic             out_valid_q;
   logic [LW-1:0]    pos_q;
   logic             zero_q;
   logic [TAG_W-1:0] tag_q;
   logic             z_last;

   assign adv         = ~out_valid_q | io.out_ready;
   assign io.in_ready = adv;

   for (genvar s = 0; s < LW; s++) begin : stg
      localparam int K = LW - 1 - s;
      localparam int H = 1 << K;
`ifdef ILOG2_FRAC_EN
      localparam int IW = WIDTH;
      localparam int OW = WIDTH;
`else
      localparam int IW = 2 * H;
      localparam int OW = H;
`endif
      logic [IW-1:0]    w_in;
      logic [LW-1:0]    c_in;
      logic             v_in;
      logic [TAG_W-1:0] t_in;
      logic             tz;
      logic [OW-1:0]    w_out;
      logic [LW-1:0]    c_out;

      if (s == 0) begin : src
         assign w_in = io.in_data;
         assign c_in = '0;
         assign v_in = io.in_valid & adv;
         assign t_in = io.in_tag;
      end else begin : src
         assign w_in = stg[s-1].r.w_q;
         assign c_in = stg[s-1].r.c_q;
         assign v_in = stg[s-1].r.v_q;
         assign t_in = stg[s-1].r.t_q;
      end

      assign tz = ~|w_in[IW-1 -: H];

`ifdef ILOG2_FRAC_EN
      assign w_out = tz ? {w_in[IW-H-1:0], {H{1'b0}}} : w_in;
`else
      // Only the half that can still hold the leading one moves on.
      assign w_out = tz ? w_in[H-1:0] : w_in[IW-1 -: H];
`endif

      always_comb begin
         c_out    = c_in;
         c_out[K] = tz;
      end

      if (s < LW - 1) begin : r
         logic             v_q;
         logic [TAG_W-1:0] t_q;
         logic [OW-1:0]    w_q;
         logic [LW-1:0]    c_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               v_q <= 1'b0;
               t_q <= '0;
               w_q <= '0;
               c_q <= '0;
            end else if (adv) begin
               v_q <= v_in;
               t_q <= t_in;
               w_q <= w_out;
               c_q <= c_out;
            end
         end
      end
   end

`ifdef ILOG2_FRAC_EN
   logic [FRAC_BITS-1:0] frac_q;
   logic [FRAC_BITS-1:0] frac_last;

   assign z_last      = ~stg[L].w_out[WIDTH-1];
   assign frac_last   = stg[L].w_out[WIDTH-2 -: FRAC_BITS];
   assign io.out_frac = frac_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frac_q <= '0;
      end else if (adv && stg[L].v_in) begin
         frac_q <= z_last ? '0 : frac_last;
      end
   end
`else
   assign z_last = ~stg[L].w_out[0];
`endif

   // Result fields only move on a valid entry so bubbles leave them at rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         pos_q       <= '0;
         zero_q      <= 1'b0;
         tag_q       <= '0;
      end else if (adv) begin
         out_valid_q <= stg[L].v_in;
         if (stg[L].v_in) begin
            zero_q <= z_last;
            pos_q  <= z_last ? '0 : ~stg[L].c_out;
            tag_q  <= stg[L].t_in;
         end
      end
   end

   assign io.out_valid = out_valid_q;
   assign io.out_pos   = pos_q;
   assign io.out_zero  = zero_q;
   assign io.out_tag   = tag_q;
endmodule

// File: tb/tb_ilog2_pipe.sv
// Self-checking bench for ilog2_pipe: directed vectors plus a queue-based
// reference model compared against the outputs every cycle.
module tb_ilog2_pipe;
   localparam int W  = 32;
   localparam int TW = 8;
   localparam int FB = 4;
   localparam int LW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ilog2_pipe_if #(.WIDTH(W), .TAG_W(TW), .FRAC_BITS(FB)) io ();

   ilog2_pipe #(.WIDTH(W), .TAG_W(TW), .FRAC_BITS(FB)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io.slave)
   );

   typedef struct {
      logic [LW-1:0] pos;
      logic          zero;
      logic [FB-1:0] frac;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_out = 0;

   logic [FB-1:0] frac_now;
`ifdef ILOG2_FRAC_EN
   assign frac_now = io.out_frac;
`else
   assign frac_now = '0;
`endif

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference: scan for the highest set bit, then read the bits below it.
   function automatic exp_t model(input logic [W-1:0] d,
                                  input logic [TW-1:0] t);
      exp_t e;
      int   p;
      e.pos  = '0;
      e.zero = (d == '0);
      e.frac = '0;
      e.tag  = t;
      p = -1;
      for (int i = 0; i < W; i++) if (d[i]) p = i;
      if (p >= 0) begin
         e.pos = LW'(p);
         for (int j = 1; j <= FB; j++)
            if (p - j >= 0) e.frac[FB-j] = d[p-j];
      end
      return e;
   endfunction

   logic          prev_stall = 1'b0;
   logic [LW-1:0] s_pos;
   logic          s_zero;
   logic [FB-1:0] s_frac;
   logic [TW-1:0] s_tag;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", io.out_valid, 1);
            chk("stall_pos", io.out_pos, s_pos);
            chk("stall_zero", io.out_zero, s_zero);
            chk("stall_tag", io.out_tag, s_tag);
            chk("stall_frac", frac_now, s_frac);
         end
         if (io.out_valid) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL spurious_out: got out_valid=1 tag=%0h expected no result",
                        io.out_tag);
            end else begin
               chk("m_pos", io.out_pos, q[0].pos);
               chk("m_zero", io.out_zero, q[0].zero);
               chk("m_tag", io.out_tag, q[0].tag);
`ifdef ILOG2_FRAC_EN
               chk("m_frac", frac_now, q[0].frac);
`endif
               if (io.out_ready) begin
                  void'(q.pop_front());
                  n_out++;
               end
            end
         end
         if (io.in_valid && io.in_ready)
            q.push_back(model(io.in_data, io.in_tag));
         prev_stall = io.out_valid && !io.out_ready;
         s_pos  = io.out_pos;
         s_zero = io.out_zero;
         s_frac = frac_now;
         s_tag  = io.out_tag;
      end
   end

   task automatic send_one(input logic [W-1:0] d, input logic [TW-1:0] t,
                           input int epos, input bit ez, input int efrac);
      int lat;
      @(posedge clk); #1;
      io.in_valid = 1'b1;
      io.in_data  = d;
      io.in_tag   = t;
      @(negedge clk);
      chk("acc_ready", io.in_ready, 1);
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (io.out_valid) begin
            lat = n;
            break;
         end
      end
      chk("latency", lat, 5);
      chk("d_pos", io.out_pos, epos);
      chk("d_zero", io.out_zero, ez);
      chk("d_tag", io.out_tag, t);
`ifdef ILOG2_FRAC_EN
      chk("d_frac", frac_now, efrac);
`else
      if (efrac < 0) chk("d_frac_arg", efrac, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      int k;
      int cyc;
      int base;
      int seen;

      io.in_valid  = 1'b0;
      io.in_data   = '0;
      io.in_tag    = '0;
      io.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", io.out_valid, 0);
      chk("rst_pos", io.out_pos, 0);
      chk("rst_zero", io.out_zero, 0);
      chk("rst_tag", io.out_tag, 0);
      chk("rst_frac", frac_now, 0);
      chk("rst_ready", io.in_ready, 1);

      send_one(32'h0000_0001, 8'h01, 0, 0, 0);
      send_one(32'h8000_0000, 8'h02, 31, 0, 0);
      send_one(32'hFFFF_FFFF, 8'h03, 31, 0, 15);
      send_one(32'h0000_0000, 8'h5A, 0, 1, 0);
      send_one(32'h0000_00C0, 8'h04, 7, 0, 8);
      send_one(32'h0000_0013, 8'h05, 4, 0, 3);
      send_one(32'h0000_FFFF, 8'h06, 15, 0, 15);
      send_one(32'h0000_0002, 8'h07, 1, 0, 0);

      // Walking-one stream under random backpressure.
      base = n_out;
      i = 0;
      cyc = 0;
      while ((i < 32 || n_out - base < 32) && cyc < 1000) begin
         @(posedge clk); #1;
         io.out_ready = 1'($urandom_range(0, 1));
         if (i < 32) begin
            io.in_valid = 1'b1;
            io.in_data  = 32'h1 << i;
            io.in_tag   = TW'(i);
         end else begin
            io.in_valid = 1'b0;
         end
         @(negedge clk);
         if (io.in_valid && io.in_ready) i++;
         cyc++;
      end
      chk("stream_accepted", i, 32);
      chk("stream_results", n_out - base, 32);
      @(posedge clk); #1;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("stream_drained", q.size(), 0);

      // Full stall: only as many operands as there are stages fit.
      base = n_out;
      io.out_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         if (k < 8) begin
            io.in_valid = 1'b1;
            io.in_data  = 32'h3 << (2 * k);
            io.in_tag   = TW'(8'h40 + k);
         end else begin
            io.in_valid = 1'b0;
         end
         @(negedge clk);
         if (io.in_valid && io.in_ready) k++;
      end
      chk("stall_accepted", k, 5);
      chk("stall_in_ready", io.in_ready, 0);
      chk("stall_no_out", n_out - base, 0);
      @(posedge clk); #1;
      io.in_valid  = 1'b0;
      io.out_ready = 1'b1;
      cyc = 0;
      while (n_out - base < 5 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      repeat (6) @(negedge clk);
      chk("stall_released", n_out - base, 5);

      // Reset with three operands in flight.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         io.in_valid = 1'b1;
         io.in_data  = 32'h7 << (4 * c);
         io.in_tag   = TW'(8'h70 + c);
      end
      @(posedge clk); #1;
      io.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", io.out_valid, 0);
      chk("mid_rst_tag", io.out_tag, 0);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (io.out_valid) seen++;
      end
      chk("mid_rst_flushed", seen, 0);
      send_one(32'h0000_0100, 8'h33, 8, 0, 0);

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
